// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
// Requester ids: reads 0..N_RD-1, write WR_ID.
package mem_resp_pkg;

  localparam int N_RD       = 4;
  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 10;

  typedef logic [2:0] port_id_t;

  localparam port_id_t WR_ID = 3'd4;

  // Stage-1 holding register; field widths follow the package word geometry.
  typedef struct packed {
    logic                  valid;
    port_id_t              port;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic                  we;
  } s1_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among the eligible read ports, searching upward from ptr.
module rr_arbiter
  import mem_resp_pkg::*;
(
  input  logic [N_RD-1:0]         elig,
  input  logic [$clog2(N_RD)-1:0] ptr,
  output logic                    gnt_valid,
  output logic [$clog2(N_RD)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N_RD);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    idx       = ptr;
    for (int i = 0; i < N_RD; i++) begin
      idx = ptr + IDX_W'(i);
      if (!gnt_valid && elig[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_responder.sv
// One-write/four-read handshaked responder over a single-port word array.
// Arbitration latches one grantee into stage 1; stage 1 performs the access and acks.
module mem_port_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = 16384
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  input  logic [N_RD-1:0]          rd_req,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD-1:0]          rd_ack,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic                     busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = $clog2(N_RD);

  s1_t              s1;
  s1_t              s1_next;
  logic [PTR_W-1:0] rr_ptr;
  logic             wr_elig;
  logic [N_RD-1:0]  rd_elig;
  logic [N_RD-1:0]  rd_hit;
  logic             rr_valid;
  logic [PTR_W-1:0] rr_idx;
  logic             s1_in_range;
  logic [DATA_W-1:0] rd_word;

  logic [ADDR_W-1:0] rd_addr_a [N_RD];
  logic [DATA_W-1:0] rd_q      [N_RD];
  logic [DATA_W-1:0] mem       [DEPTH];

  always_comb begin
    for (int p = 0; p < N_RD; p++) begin
      rd_addr_a[p]                  = rd_addr[p*ADDR_W +: ADDR_W];
      rd_data[p*DATA_W +: DATA_W]   = rd_q[p];
    end
  end

  // A port already in stage 1, or acking this cycle, sits out this edge.
  always_comb begin
    wr_elig = wr_req && !(s1.valid && s1.we) && !wr_ack;
    for (int p = 0; p < N_RD; p++) begin
      rd_hit[p]  = s1.valid && !s1.we && (s1.port == port_id_t'(p));
      rd_elig[p] = rd_req[p] && !rd_hit[p] && !rd_ack[p];
    end
  end

  rr_arbiter u_arb (
    .elig      (rd_elig),
    .ptr       (rr_ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  always_comb begin
    s1_next = '0;
    if (wr_elig) begin
      s1_next.valid = 1'b1;
      s1_next.we    = 1'b1;
      s1_next.port  = WR_ID;
      s1_next.addr  = wr_addr;
      s1_next.data  = wr_data;
    end else if (rr_valid) begin
      s1_next.valid = 1'b1;
      s1_next.port  = port_id_t'(rr_idx);
      s1_next.addr  = rd_addr_a[rr_idx];
    end
  end

  assign s1_in_range = 32'(s1.addr) < DEPTH;
  assign rd_word     = s1_in_range ? mem[s1.addr[IDX_W-1:0]] : '0;
  assign busy        = s1.valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= '0;
      rr_ptr <= '0;
      wr_ack <= 1'b0;
      rd_ack <= '0;
      for (int p = 0; p < N_RD; p++) rd_q[p] <= '0;
    end else begin
      s1     <= s1_next;
      if (!wr_elig && rr_valid) rr_ptr <= rr_idx + PTR_W'(1);
      wr_ack <= s1.valid && s1.we;
      rd_ack <= rd_hit;
      for (int p = 0; p < N_RD; p++) begin
        if (rd_hit[p]) rd_q[p] <= rd_word;
      end
    end
  end

  // Array is not reset; out-of-range writes are acked but dropped.
  always_ff @(posedge clk) begin
    if (s1.valid && s1.we && s1_in_range) mem[s1.addr[IDX_W-1:0]] <= s1.data;
  end

endmodule
